// File: rtl/frame_color_analyzer.sv
// frame_color_analyzer: scans a 160x120 RGB332 frame, counts red/green/blue pixels and reports the dominant colour
module frame_color_analyzer #(
    parameter int CAM_SCREEN_X = 160,
    parameter int CAM_SCREEN_Y = 120,
    parameter int AW           = 15,
    parameter int DW           = 8,
    parameter int MIN_PIX      = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    output logic          busy,
    output logic          done,
    output logic [1:0]    color,
    output logic [AW-1:0] red_count,
    output logic [AW-1:0] green_count,
    output logic [AW-1:0] blue_count
);
    localparam logic [AW-1:0] LAST = AW'(CAM_SCREEN_X * CAM_SCREEN_Y - 1);
    localparam logic [AW-1:0] MIN  = AW'(MIN_PIX);

    typedef enum logic [2:0] {IDLE, READ, DRAIN, DECIDE, DONE} state_t;

    state_t        r_state;
    logic          r_vld;
    logic [2:0]    w_r;
    logic [2:0]    w_g;
    logic [1:0]    w_b;
    logic          w_red;
    logic          w_green;
    logic          w_blue;
    logic [1:0]    w_pick;
    logic [AW-1:0] w_max;
    logic [1:0]    w_color;

    // pixel classification and dominant-colour verdict (ties favour red, then green)
    always_comb begin
        w_r     = mem_data[7:5];
        w_g     = mem_data[4:2];
        w_b     = mem_data[1:0];
        w_red   = (w_r >= 3'd5) && (w_g <= 3'd3) && (w_b <= 2'd1);
        w_green = (w_g >= 3'd5) && (w_r <= 3'd3) && (w_b <= 2'd1);
        w_blue  = (w_b >= 2'd2) && (w_r <= 3'd3) && (w_g <= 3'd3);
        w_pick  = (red_count >= green_count && red_count >= blue_count) ? 2'b01 :
                  (green_count >= blue_count) ? 2'b10 : 2'b11;
        w_max   = (w_pick == 2'b01) ? red_count : (w_pick == 2'b10) ? green_count : blue_count;
        w_color = (w_max >= MIN) ? w_pick : 2'b00;
    end

    // scan FSM; r_vld marks cycles where mem_data holds a pixel issued the cycle before
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_vld       <= 1'b0;
            mem_addr    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            color       <= 2'b00;
            red_count   <= '0;
            green_count <= '0;
            blue_count  <= '0;
        end else begin
            r_vld <= (r_state == READ);
            if (r_vld) begin
                red_count   <= red_count + AW'(w_red);
                green_count <= green_count + AW'(w_green);
                blue_count  <= blue_count + AW'(w_blue);
            end
            case (r_state)
                IDLE: begin
                    mem_addr <= '0;
                    if (start) begin
                        r_state     <= READ;
                        busy        <= 1'b1;
                        red_count   <= '0;
                        green_count <= '0;
                        blue_count  <= '0;
                    end
                end
                READ: begin
                    if (mem_addr == LAST) begin
                        r_state  <= DRAIN;
                        mem_addr <= '0;
                    end else begin
                        mem_addr <= mem_addr + 1'b1;
                    end
                end
                DRAIN: r_state <= DECIDE;
                DECIDE: begin
                    color   <= w_color;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_color_analyzer.sv
// tb_frame_color_analyzer: directed scans over a modelled frame buffer with hand-computed counts and verdicts
module tb_frame_color_analyzer;
    localparam int N  = 19200;
    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          start2 = 1'b0;
    logic [AW-1:0] mem_addr, mem_addr2;
    logic [7:0]    mem_data = 8'h00;
    logic [7:0]    mem_data2 = 8'h00;
    logic          busy, done, busy2, done2;
    logic [1:0]    color, color2;
    logic [AW-1:0] red_count, green_count, blue_count;
    logic [AW-1:0] red_count2, green_count2, blue_count2;
    logic [7:0]    mem_a [N];
    logic [7:0]    mem_b [N];
    int            checks = 0;
    int            errors = 0;
    int            done_cnt = 0;
    int            overlap = 0;

    frame_color_analyzer dut (
        .clk(clk), .rst(rst_n), .start(start), .mem_addr(mem_addr), .mem_data(mem_data),
        .busy(busy), .done(done), .color(color),
        .red_count(red_count), .green_count(green_count), .blue_count(blue_count)
    );

    frame_color_analyzer #(.MIN_PIX(128)) dut2 (
        .clk(clk), .rst(rst_n), .start(start2), .mem_addr(mem_addr2), .mem_data(mem_data2),
        .busy(busy2), .done(done2), .color(color2),
        .red_count(red_count2), .green_count(green_count2), .blue_count(blue_count2)
    );

    always #20 clk = ~clk;

    always @(posedge clk) begin
        mem_data  <= mem_a[mem_addr];
        mem_data2 <= mem_b[mem_addr2];
        done_cnt  <= done_cnt + int'(done);
    end

    always @(negedge clk) if (done && busy) overlap <= overlap + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < N; i++) begin
            mem_a[i] = v;
            mem_b[i] = v;
        end
    endtask

    task automatic scan(input bit both, input int repulse);
        int cyc, addr_bad, busy_bad, d0;
        bit seen;
        cyc = 0; addr_bad = 0; busy_bad = 0; seen = 0;
        d0 = done_cnt;
        @(negedge clk); start = 1'b1; start2 = both;
        @(negedge clk); start = 1'b0; start2 = 1'b0; cyc = 1;
        while (!seen && cyc <= N + 10) begin
            if (done) seen = 1'b1;
            else begin
                if (cyc <= N && mem_addr !== AW'(cyc - 1)) addr_bad++;
                if (cyc <= N + 2 && busy !== 1'b1) busy_bad++;
                if (cyc == repulse) start = 1'b1;
                @(negedge clk); start = 1'b0; cyc++;
            end
        end
        check("done_seen", 32'(seen), 1);
        check("done_cycle", cyc, N + 3);
        check("busy_at_done", 32'(busy), 0);
        check("addr_seq", addr_bad, 0);
        check("busy_span", busy_bad, 0);
        repeat (4) @(negedge clk);
        check("done_pulses", done_cnt - d0, 1);
    endtask

    initial begin
        fill(8'h00);
        repeat (2) @(negedge clk);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_color", 32'(color), 0);
        check("rst_red", 32'(red_count), 0);
        check("rst_green", 32'(green_count), 0);
        check("rst_blue", 32'(blue_count), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_addr", 32'(mem_addr), 0);

        fill(8'hE0);
        scan(1'b0, 500);
        check("red_all_r", 32'(red_count), N);
        check("red_all_g", 32'(green_count), 0);
        check("red_all_b", 32'(blue_count), 0);
        check("red_all_color", 32'(color), 1);

        fill(8'h00);
        begin
            int d0;
            d0 = done_cnt;
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
            repeat (999) @(negedge clk);
            check("pre_abort_busy", 32'(busy), 1);
            rst_n = 1'b0;
            #1;
            check("abort_busy", 32'(busy), 0);
            check("abort_red", 32'(red_count), 0);
            check("abort_addr", 32'(mem_addr), 0);
            check("abort_color", 32'(color), 0);
            @(negedge clk); rst_n = 1'b1;
            repeat (6) @(negedge clk);
            check("abort_no_done", done_cnt - d0, 0);
            check("abort_idle", 32'(busy), 0);
        end

        scan(1'b0, -1);
        check("zero_r", 32'(red_count), 0);
        check("zero_g", 32'(green_count), 0);
        check("zero_b", 32'(blue_count), 0);
        check("zero_color", 32'(color), 0);

        fill(8'h00);
        for (int i = 0; i < 100; i++) begin mem_a[i] = 8'h1C; mem_b[i] = 8'h1C; end
        for (int i = 100; i < 150; i++) begin mem_a[i] = 8'h03; mem_b[i] = 8'h03; end
        scan(1'b1, -1);
        check("grn_r", 32'(red_count), 0);
        check("grn_g", 32'(green_count), 100);
        check("grn_b", 32'(blue_count), 50);
        check("grn_color", 32'(color), 2);
        check("grn_min128_g", 32'(green_count2), 100);
        check("grn_min128_color", 32'(color2), 0);

        fill(8'h00);
        for (int i = 0; i < 100; i++) mem_a[i] = 8'hE0;
        for (int i = 100; i < 200; i++) mem_a[i] = 8'h1C;
        mem_b[0] = 8'hA0;
        mem_b[1] = 8'h80;
        mem_b[2] = 8'h02;
        mem_b[3] = 8'hE2;
        mem_b[N-1] = 8'h03;
        scan(1'b1, -1);
        check("tie_r", 32'(red_count), 100);
        check("tie_g", 32'(green_count), 100);
        check("tie_b", 32'(blue_count), 0);
        check("tie_color", 32'(color), 1);
        check("bnd_r", 32'(red_count2), 1);
        check("bnd_g", 32'(green_count2), 0);
        check("bnd_b", 32'(blue_count2), 2);
        check("bnd_color", 32'(color2), 0);
        check("done_busy_overlap", overlap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
